// File: rtl/sw_pkg.sv
// Shared types, scoring constants and the clamping max used by every
// Smith-Waterman processing element.
package sw_pkg;

    localparam int NUM_PE   = 64;
    localparam int SCORE_W  = 14;
    localparam int POS_W    = 10;
    localparam int MATCH    = 2;
    localparam int MISMATCH = 1;
    localparam int GAP      = 1;

    typedef logic [1:0]         base_t;
    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [POS_W-1:0]   pos_t;
    typedef logic signed [SCORE_W:0] wide_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam wide_t MATCH_S    = wide_t'(MATCH);
    localparam wide_t MISMATCH_S = wide_t'(MISMATCH);
    localparam wide_t GAP_S      = wide_t'(GAP);
    localparam wide_t SCORE_SAT  = wide_t'((1 << SCORE_W) - 1);

    // Local-alignment recurrence: never below zero, pinned at the top of the score range.
    function automatic score_t swMax(input wide_t diagTerm,
                                     input wide_t upTerm,
                                     input wide_t leftTerm);
        wide_t best;
        best = '0;
        if (diagTerm > best) best = diagTerm;
        if (upTerm > best)   best = upTerm;
        if (leftTerm > best) best = leftTerm;
        if (best > SCORE_SAT) best = SCORE_SAT;
        return best[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/sw_pe_cell.sv
// One Smith-Waterman PE: scores the A base arriving from its left neighbour
// against its fixed B base and forwards base, valid and A index one stage on.
module sw_pe_cell
    import sw_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   clear_i,
    input  base_t  b_i,
    input  base_t  a_i,
    input  logic   valid_i,
    input  pos_t   idx_i,
    input  score_t left_i,
    input  score_t diag_i,
    output base_t  a_o,
    output logic   valid_o,
    output pos_t   idx_o,
    output score_t h_o,
    output score_t hPrev_o
);

    score_t h_q, h_d;
    score_t diag_q, diag_d;
    base_t  a_q;
    logic   valid_q;
    pos_t   idx_q;

    score_t upScore;
    score_t hNew;
    wide_t  diagTerm, upTerm, leftTerm;

    // H and its one-cycle-old copy only move on a valid base, so bubbles keep
    // the neighbour's diagonal aligned. A stripe start makes Hup read as zero.
    always_comb begin
        upScore  = clear_i ? '0 : h_q;
        diagTerm = $signed({1'b0, diag_i}) + ((a_i == b_i) ? MATCH_S : -MISMATCH_S);
        upTerm   = $signed({1'b0, upScore}) - GAP_S;
        leftTerm = $signed({1'b0, left_i}) - GAP_S;
        hNew     = swMax(diagTerm, upTerm, leftTerm);

        h_d    = h_q;
        diag_d = diag_q;
        if (clear_i) begin
            h_d    = valid_i ? hNew : '0;
            diag_d = '0;
        end else if (valid_i) begin
            h_d    = hNew;
            diag_d = h_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q     <= '0;
            diag_q  <= '0;
            a_q     <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            h_q     <= h_d;
            diag_q  <= diag_d;
            a_q     <= a_i;
            valid_q <= valid_i;
            idx_q   <= idx_i;
        end
    end

    assign a_o     = a_q;
    assign valid_o = valid_q;
    assign idx_o   = idx_q;
    assign h_o     = h_q;
    assign hPrev_o = diag_q;

endmodule

// File: rtl/sw_pe_array_64.sv
// 64-PE systolic Smith-Waterman stripe scorer: streams A past a static B stripe
// and reports the stripe maximum, the first PE63 hit position and drain completion.
module sw_pe_array_64
    import sw_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [2*NUM_PE-1:0]   i_B,
    input  logic [1:0]            i_A,
    output logic                  o_stripe_end,
    output logic [POS_W-1:0]      o_start_position,
    output logic [SCORE_W-1:0]    o_max_score_stripe
);

    state_e state_q, state_d;
    pos_t   cnt_q, cnt_d;
    score_t max_q, max_d;
    pos_t   pos_q, pos_d;
    logic   found_q, found_d;
    logic   end_q, end_d;

    base_t  aChain     [NUM_PE+1];
    pos_t   idxChain   [NUM_PE+1];
    score_t hChain     [NUM_PE+1];
    score_t hPrevChain [NUM_PE+1];
    logic [NUM_PE:0] validChain;

    logic   startNow;
    logic   drained;
    score_t stripeMax;
    logic   unusedTail;

    assign startNow      = i_start && (state_q != ST_RUN);
    assign aChain[0]     = i_A;
    assign validChain[0] = i_start;
    assign idxChain[0]   = startNow ? '0 : cnt_q;
    assign hChain[0]     = '0;
    assign hPrevChain[0] = '0;

    // Chain element k+1 holds the registered outputs of PE k.
    for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
        sw_pe_cell u_cell (
            .clk_i   (i_clk),
            .rst_i   (i_rst),
            .clear_i (startNow),
            .b_i     (i_B[2*k +: 2]),
            .a_i     (aChain[k]),
            .valid_i (validChain[k]),
            .idx_i   (idxChain[k]),
            .left_i  (hChain[k]),
            .diag_i  (hPrevChain[k]),
            .a_o     (aChain[k+1]),
            .valid_o (validChain[k+1]),
            .idx_o   (idxChain[k+1]),
            .h_o     (hChain[k+1]),
            .hPrev_o (hPrevChain[k+1])
        );
    end

    assign unusedTail = ^{aChain[NUM_PE], hPrevChain[NUM_PE]};

    // With PE0..PE62 empty and no new base, PE63 is scoring its last cell now.
    assign drained = ~|validChain[NUM_PE-1:1];

    always_comb begin
        stripeMax = max_q;
        for (int k = 1; k <= NUM_PE; k++) begin
            if (validChain[k] && (hChain[k] > stripeMax)) stripeMax = hChain[k];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        pos_d   = pos_q;
        found_d = found_q;
        end_d   = end_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    cnt_d   = pos_t'(1);
                    max_d   = '0;
                    pos_d   = '0;
                    found_d = 1'b0;
                    end_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (i_start) cnt_d = cnt_q + pos_t'(1);
                max_d = stripeMax;
                if (!found_q && validChain[NUM_PE] && (hChain[NUM_PE] != '0)) begin
                    found_d = 1'b1;
                    pos_d   = idxChain[NUM_PE];
                end
                if (!i_start && drained) begin
                    state_d = ST_DONE;
                    end_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            max_q   <= '0;
            pos_q   <= '0;
            found_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            pos_q   <= pos_d;
            found_q <= found_d;
            end_q   <= end_d;
        end
    end

    assign o_stripe_end       = end_q;
    assign o_start_position   = pos_q;
    assign o_max_score_stripe = max_q;

endmodule

// File: tb/tb_sw_pe_array_64.sv
// Directed self-checking bench for sw_pe_array_64: hand-derived stripe scores,
// start positions, drain timing, restart clearing and asynchronous reset.
module tb_sw_pe_array_64;

    logic         clk;
    logic         rst;
    logic         iStart;
    logic [127:0] iB;
    logic [1:0]   iA;
    logic         oStripeEnd;
    logic [9:0]   oStartPosition;
    logic [13:0]  oMaxScore;

    int checkCount;
    int passCount;
    int failCount;

    sw_pe_array_64 dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_start            (iStart),
        .i_B                (iB),
        .i_A                (iA),
        .o_stripe_end       (oStripeEnd),
        .o_start_position   (oStartPosition),
        .o_max_score_stripe (oMaxScore)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge so the DUT samples them cleanly at the next rise.
    task automatic applyStimulus(input logic [1:0] a, input logic start);
        @(negedge clk);
        iA     = a;
        iStart = start;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Constant-valued stripe: first `split` bases are `first`, the rest `second`.
    task automatic feedStripe(input int n, input int split,
                              input logic [1:0] first, input logic [1:0] second);
        for (int i = 0; i < n; i++) applyStimulus((i < split) ? first : second, 1'b1);
    endtask

    // Stripe end must still be low 63 edges after the last base and high on the 64th.
    task automatic drainAndCheck(input string tag);
        for (int i = 0; i < 64; i++) applyStimulus(2'd0, 1'b0);
        checkOutput({tag, "_end_early"}, 32'(oStripeEnd), 32'd0);
        applyStimulus(2'd0, 1'b0);
        checkOutput({tag, "_end"}, 32'(oStripeEnd), 32'd1);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        rst    = 1'b1;
        iStart = 1'b0;
        iA     = 2'd0;
        iB     = '0;

        // Reset with no stimulus.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus(2'd0, 1'b0);
        checkOutput("reset_end", 32'(oStripeEnd), 32'd0);
        checkOutput("reset_max", 32'(oMaxScore), 32'd0);
        checkOutput("reset_pos", 32'(oStartPosition), 32'd0);

        // B all 0, A all 0: full diagonal of matches gives 64*2.
        iB = '0;
        feedStripe(1024, 1024, 2'd0, 2'd0);
        drainAndCheck("allmatch");
        checkOutput("allmatch_max", 32'(oMaxScore), 32'd128);
        checkOutput("allmatch_pos", 32'(oStartPosition), 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(2'd0, 1'b0);
        checkOutput("allmatch_hold_max", 32'(oMaxScore), 32'd128);
        checkOutput("allmatch_hold_end", 32'(oStripeEnd), 32'd1);

        // B all 0, A all 1: nothing ever scores.
        feedStripe(1024, 1024, 2'd1, 2'd1);
        drainAndCheck("nomatch");
        checkOutput("nomatch_max", 32'(oMaxScore), 32'd0);
        checkOutput("nomatch_pos", 32'(oStartPosition), 32'd0);

        // B copies A[0..63]; the main diagonal alone reaches the 128 ceiling.
        for (int k = 0; k < 64; k++) iB[2*k +: 2] = 2'(k % 4);
        for (int i = 0; i < 256; i++)
            applyStimulus((i < 64) ? 2'(i % 4) : 2'($urandom_range(3, 0)), 1'b1);
        drainAndCheck("copy");
        checkOutput("copy_max", 32'(oMaxScore), 32'd128);

        // B all 0, A[0..99]=1 then 0: row 100 is the first row with any positive cell.
        iB = '0;
        feedStripe(1024, 100, 2'd1, 2'd0);
        drainAndCheck("offset");
        checkOutput("offset_max", 32'(oMaxScore), 32'd128);
        checkOutput("offset_pos", 32'(oStartPosition), 32'd100);

        // New stripe with B all 3: results from the previous stripe clear on the first start.
        iB = '1;
        applyStimulus(2'd3, 1'b1);
        applyStimulus(2'd3, 1'b1);
        checkOutput("restart_max", 32'(oMaxScore), 32'd0);
        checkOutput("restart_pos", 32'(oStartPosition), 32'd0);
        checkOutput("restart_end", 32'(oStripeEnd), 32'd0);
        feedStripe(298, 298, 2'd3, 2'd3);
        checkOutput("prereset_max", 32'(oMaxScore), 32'd128);
        checkOutput("prereset_pos", 32'(oStartPosition), 32'd0);
        checkOutput("prereset_end", 32'(oStripeEnd), 32'd0);

        // Reset lands between clock edges; outputs must drop before the next rise.
        #2;
        rst    = 1'b1;
        iStart = 1'b0;
        #1;
        checkOutput("asyncrst_max", 32'(oMaxScore), 32'd0);
        checkOutput("asyncrst_pos", 32'(oStartPosition), 32'd0);
        checkOutput("asyncrst_end", 32'(oStripeEnd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 80; i++) applyStimulus(2'd0, 1'b0);
        checkOutput("postrst_end", 32'(oStripeEnd), 32'd0);

        // Fresh all-match stripe after reset.
        feedStripe(200, 200, 2'd3, 2'd3);
        drainAndCheck("fresh");
        checkOutput("fresh_max", 32'(oMaxScore), 32'd128);
        checkOutput("fresh_pos", 32'(oStartPosition), 32'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sw_pe_array_64.md
Name: sw_pe_array_64

Overview:
- Linear systolic array of 64 Smith-Waterman processing elements (PEs) that scores one 64-base stripe of query B against a streamed reference A.
- B (64 bases, 2-bit encoded) is held static on i_B. A is fed one base per cycle.
- Reports the stripe's maximum local-alignment score and where the next stripe may start.
- Sits between the sequence memories and the stripe controller of the gene alignment engine.

Parameters:
- NUM_PE, 64, number of PEs (B bases per stripe)
- SCORE_W, 14, score width (unsigned)
- POS_W, 10, A-position width (max 1024 bases per stripe)
- MATCH, 2, score added on base match
- MISMATCH, 1, penalty subtracted on mismatch
- GAP, 1, linear gap penalty

Ports:
- i_clk  in  1  clock, rising edge. One clock; reset is asynchronous and active-high.
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  i_A valid this cycle; rising edge starts a new stripe
- i_B  in  128  query stripe; base k = i_B[2k+1:2k], stable for the whole stripe
- i_A  in  2  reference base, sampled when i_start=1
- o_stripe_end  out  1  stripe fully drained; results valid
- o_start_position  out  10  stripe-relative A index of first positive PE63 score
- o_max_score_stripe  out  14  maximum H over all cells of the stripe

Behaviour:
- Reset (async): all H/diag/base/valid registers = 0; o_stripe_end=0, o_start_position=0, o_max_score_stripe=0; internal found flag=0, A counter=0.
- Stripe start: on the first cycle with i_start=1 after reset or after o_stripe_end=1, the following are cleared in that same cycle: H registers, max, found flag, A counter, o_stripe_end. The base presented in that cycle is A index 0.
- Pipeline:
  - The A base and its valid bit shift PE k to PE k+1 every cycle, whether or not i_start is high.
  - PE k processes A[j] at cycle t0+j+k, where t0 is the cycle the base is sampled.
- PE k (base b=B[k]) computes for each valid A[j]:
  - H(j,k) = max(0, Hdiag + s, Hup − GAP, Hleft − GAP)
  - s = +MATCH if equal, −MISMATCH otherwise.
  - Hup = PE k's previous H, i.e. H(j−1,k).
  - Hleft = H(j,k−1) from PE k−1, registered.
  - Hdiag = H(j−1,k−1), PE k−1's previous output delayed one cycle.
  - PE0 uses Hleft=Hdiag=0. Row j=0 uses Hup=0 and Hdiag=0.
- Arithmetic: compute in SCORE_W+1 bits signed; clamp low at 0; saturate high at 2^SCORE_W−1.
- Max: each cycle, o_max_score_stripe = max(itself, every valid PE's H).
- Start position:
  - The A counter increments per accepted base; each base carries its index down the pipe.
  - The first time PE63 outputs a valid H>0, o_start_position latches that base's index and the found flag is set.
  - If no such cell occurs, o_start_position stays 0.
- Stripe end: after i_start falls, o_stripe_end rises once no valid base remains in any PE. That is 64 cycles after the last accepted base's edge.
  - o_stripe_end is held high until the next stripe start.
  - Results are held stable while o_stripe_end=1.
- i_start low mid-stripe (gap in input): bubbles propagate. A single gap ends the stripe only once the pipe fully drains; a stall shorter than the drain time does not end it.
- Reset mid-stripe: immediate return to reset state; no stripe_end pulse.
- More than 1024 accepted bases: the counter wraps. Position behaviour beyond 1024 bases is unsupported.

Decomposition:
- Package sw_pkg holds:
  - base typedef (2-bit) and score typedef (SCORE_W)
  - MATCH/MISMATCH/GAP constants
  - saturating/clamping max function
- One sub-module sw_pe_cell: one PE with registered H, diag, base, valid and index forwarding. Instantiate 64 times via generate.
- The top level holds the A counter, max tree/reduction, start-position latch and drain detection.

Test Plan:
- Reset, no stimulus → all outputs 0; o_stripe_end stays 0.
- B all 0, 1024 A bases all 0 → o_max_score_stripe=128, o_start_position=0, o_stripe_end rises 64 cycles after last i_start.
- B all 0, A all 1 (1024 bases) → max=0, start_position=0, stripe_end asserts.
- B all 0, A[0..99]=1 then A[100..1023]=0 → start_position=100, max=128.
- B = A[0..63] exact copy, remaining A random → max ≥128. Then start a second stripe with new i_B → max, start_position and stripe_end clear on the first i_start cycle.
- Assert i_rst mid-stripe (after 300 bases) → outputs 0 asynchronously. A fresh stripe afterwards reproduces the all-match result (max=128).
